// File: rtl/epd_param_if.sv
// Byte-serial receive stream feeding the Ethernet packet detector.
// The receive side drives one byte per clock; `control` frames the packet.
interface epd_param_if;
    logic [7:0] data;
    logic       control;

    modport master (output data, output control);
    modport slave  (input  data, input  control);
endinterface

// File: rtl/epd_param.sv
// Byte-serial Ethernet frame checker: walks preamble/SFD and the MAC header,
// flags each field, and qualifies the frame by size, length field and filtering.
module epd_param #(
    parameter int PRE_LEN   = 7,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int CNT_W     = 4,
    parameter int LEN_CHECK = 1
) (
    input  logic              clock,
    input  logic              reset,
    epd_param_if.slave        rx,
    input  logic [47:0]       local_mac,
    input  logic              promisc,
    output logic              preamble_valid,
    output logic              dst_addr_valid,
    output logic              src_addr_valid,
    output logic              type_length_valid,
    output logic              packet_size_valid,
    output logic              packet_valid,
    output logic              frame_error,
    output logic [CNT_W-1:0]  valid_packet_counter
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam int IDX_W = $clog2((PRE_LEN > 6) ? PRE_LEN : 6);
    localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);
    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_DROP
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]   len;
    logic               ctrl_q;
    logic               start, eof, abort;

    // Header accumulators; only meaningful once their field is complete.
    logic               dst_local_m, dst_bcast_m, src_mc, src_nz;
    logic [7:0]         type_hi;
    logic [15:0]        type_field;

    logic [7:0]         mac_byte;
    logic               dst_local_n, dst_bcast_n, src_mc_n, src_nz_n;
    logic [15:0]        field_n;
    logic               size_ok, len_ok, good;

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (v >= LEN_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic type_ok(input logic [15:0] f);
        return (f <= 16'd1500) || (f >= 16'h0600);
    endfunction

    always_comb begin
        mac_byte = local_mac[7:0];
        case (idx)
            IDX_W'(0): mac_byte = local_mac[47:40];
            IDX_W'(1): mac_byte = local_mac[39:32];
            IDX_W'(2): mac_byte = local_mac[31:24];
            IDX_W'(3): mac_byte = local_mac[23:16];
            IDX_W'(4): mac_byte = local_mac[15:8];
            default:   mac_byte = local_mac[7:0];
        endcase
    end

    assign dst_local_n = ((idx == '0) ? 1'b1 : dst_local_m) & (rx.data == mac_byte);
    assign dst_bcast_n = ((idx == '0) ? 1'b1 : dst_bcast_m) & (rx.data == 8'hFF);
    assign src_mc_n    = (idx == '0) ? rx.data[0] : src_mc;
    assign src_nz_n    = ((idx == '0) ? 1'b0 : src_nz) | (rx.data != 8'h00);
    assign field_n     = {type_hi, rx.data};

    assign size_ok = (int'(len) >= MIN_LEN) && (int'(len) <= MAX_LEN);
    assign len_ok  = (LEN_CHECK == 0) || (type_field >= 16'h0600) ||
                     (int'(len) >= int'(type_field) + 18);
    assign good    = preamble_valid & dst_addr_valid & src_addr_valid &
                     type_length_valid & size_ok & len_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // A frame only opens on a rising `control`, so a reset released mid-frame
    // waits for the line to go quiet first.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        start   = 1'b0;
        eof     = 1'b0;
        abort   = 1'b0;
        if (state != S_IDLE && !rx.control) begin
            state_n = S_IDLE;
            idx_n   = '0;
            if (state == S_PAYLOAD) eof = 1'b1;
            else                    abort = 1'b1;
        end else begin
            case (state)
                S_IDLE: if (rx.control && !ctrl_q) begin
                    start = 1'b1;
                    idx_n = '0;
                    if (rx.data != PRE_BYTE) state_n = S_DROP;
                    else if (PRE_LEN == 1)   state_n = S_SFD;
                    else begin
                        state_n = S_PREAMBLE;
                        idx_n   = IDX_W'(1);
                    end
                end
                S_PREAMBLE: begin
                    if (rx.data != PRE_BYTE) state_n = S_DROP;
                    else if (idx == IDX_W'(PRE_LEN - 1)) begin
                        state_n = S_SFD;
                        idx_n   = '0;
                    end else idx_n = idx + 1'b1;
                end
                S_SFD: state_n = (rx.data == SFD_BYTE) ? S_DST : S_DROP;
                S_DST: begin
                    if (idx == IDX_W'(5)) begin
                        state_n = S_SRC;
                        idx_n   = '0;
                    end else idx_n = idx + 1'b1;
                end
                S_SRC: begin
                    if (idx == IDX_W'(5)) begin
                        state_n = S_TYPE;
                        idx_n   = '0;
                    end else idx_n = idx + 1'b1;
                end
                S_TYPE: begin
                    if (idx == IDX_W'(1)) begin
                        state_n = S_PAYLOAD;
                        idx_n   = '0;
                    end else idx_n = idx + 1'b1;
                end
                S_PAYLOAD: state_n = S_PAYLOAD;
                S_DROP:    state_n = S_DROP;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q               <= 1'b1;
            len                  <= '0;
            preamble_valid       <= 1'b0;
            dst_addr_valid       <= 1'b0;
            src_addr_valid       <= 1'b0;
            type_length_valid    <= 1'b0;
            packet_size_valid    <= 1'b0;
            packet_valid         <= 1'b0;
            frame_error          <= 1'b0;
            valid_packet_counter <= '0;
        end else begin
            ctrl_q            <= rx.control;
            packet_size_valid <= 1'b0;
            packet_valid      <= 1'b0;
            frame_error       <= 1'b0;
            if (start) begin
                preamble_valid    <= 1'b0;
                dst_addr_valid    <= 1'b0;
                src_addr_valid    <= 1'b0;
                type_length_valid <= 1'b0;
                len               <= '0;
            end
            if (rx.control) begin
                case (state)
                    S_SFD: if (rx.data == SFD_BYTE) preamble_valid <= 1'b1;
                    S_DST: begin
                        len <= len_sat_inc(len);
                        if (idx == IDX_W'(5))
                            dst_addr_valid <= promisc | dst_local_n | dst_bcast_n;
                    end
                    S_SRC: begin
                        len <= len_sat_inc(len);
                        if (idx == IDX_W'(5))
                            src_addr_valid <= !src_mc_n && src_nz_n;
                    end
                    S_TYPE: begin
                        len <= len_sat_inc(len);
                        if (idx == IDX_W'(1))
                            type_length_valid <= type_ok(field_n);
                    end
                    S_PAYLOAD: len <= len_sat_inc(len);
                    default: ;
                endcase
            end
            if (eof) begin
                packet_size_valid <= size_ok;
                packet_valid      <= good;
                frame_error       <= !good;
                if (good) valid_packet_counter <= cnt_sat_inc(valid_packet_counter);
            end
            if (abort) frame_error <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rx.control) begin
            case (state)
                S_DST: begin
                    dst_local_m <= dst_local_n;
                    dst_bcast_m <= dst_bcast_n;
                end
                S_SRC: begin
                    src_mc <= src_mc_n;
                    src_nz <= src_nz_n;
                end
                S_TYPE: begin
                    if (idx == '0) type_hi <= rx.data;
                    else           type_field <= field_n;
                end
                default: ;
            endcase
        end
    end

endmodule
